// File: rtl/nn_rb_pkg.sv
// Shared constants and state encoding for the NN readback sequencer.
package nn_rb_pkg;

  localparam int NUM_WORDS = 35;

  localparam logic [8:0] ADDR_LISTO   = 9'h000;
  localparam logic [8:0] ADDR_DATO    = 9'h004;
  localparam logic [8:0] ADDR_ERROR   = 9'h008;
  localparam logic [8:0] ADDR_ENTRADA = 9'h060;
  localparam logic [8:0] ADDR_LAST    = 9'h088;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROC_RD   = 3'd1,
    DUMP_RD   = 3'd2,
    DUMP_WAIT = 3'd3,
    DONE      = 3'd4
  } rb_state_e;

  function automatic logic [8:0] word_addr(input logic [6:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/nn_rb_snapshot.sv
// Sticky result/error flags, result snapshot, and the one-deep pending
// capture used while a dump is streaming out the current snapshot.
module nn_rb_snapshot #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             listo,
  input  logic             error_in,
  input  logic [Width-1:0] dato_in,
  input  logic [Width-1:0] entrada_in,
  input  logic             clear_flags,
  input  logic             clr_listo_rd,
  input  logic             clr_err_rd,
  input  logic             dump_active,
  input  logic             apply_pending,
  output logic             listo_flag,
  output logic             err_flag,
  output logic [Width-1:0] snap_dato,
  output logic [Width-1:0] snap_entrada
);

  logic             pend_q;
  logic [Width-1:0] pend_dato_q;
  logic [Width-1:0] pend_entrada_q;
  logic             take_live;
  logic             take_pend;

  // A result arriving in the apply cycle is newer than anything pending.
  assign take_live = listo & (~dump_active | apply_pending);
  assign take_pend = apply_pending & pend_q & ~listo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      listo_flag     <= 1'b0;
      err_flag       <= 1'b0;
      snap_dato      <= '0;
      snap_entrada   <= '0;
      pend_q         <= 1'b0;
      pend_dato_q    <= '0;
      pend_entrada_q <= '0;
    end else begin
      if (take_live || take_pend)
        listo_flag <= 1'b1;
      else if (clear_flags || clr_listo_rd)
        listo_flag <= 1'b0;

      if (error_in)
        err_flag <= 1'b1;
      else if (clear_flags || clr_err_rd)
        err_flag <= 1'b0;

      if (take_live) begin
        snap_dato    <= dato_in;
        snap_entrada <= entrada_in;
      end else if (take_pend) begin
        snap_dato    <= pend_dato_q;
        snap_entrada <= pend_entrada_q;
      end

      if (apply_pending) begin
        pend_q <= 1'b0;
      end else if (listo && dump_active) begin
        pend_q         <= 1'b1;
        pend_dato_q    <= dato_in;
        pend_entrada_q <= entrada_in;
      end
    end
  end

endmodule

// File: rtl/nn_readback_sequencer.sv
// Readback sequencer: serves processor reads and full-map dumps from the
// register bank. Define NN_RB_CLEAR_ON_READ_EN for clear-on-read flags.
module nn_readback_sequencer
  import nn_rb_pkg::*;
#(
  parameter int Width    = 4,
  parameter int NumWords = NUM_WORDS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Listo,
  input  logic             ErrorIn,
  input  logic [Width-1:0] DatoIn,
  input  logic [Width-1:0] EntradaIn,
  input  logic             ClearFlags,
  input  logic             RdReq,
  input  logic [8:0]       RdAddr,
  output logic [Width-1:0] RdData,
  output logic             RdValid,
  input  logic             DumpStart,
  output logic             DumpValid,
  input  logic             DumpReady,
  output logic [8:0]       DumpAddr,
  output logic [Width-1:0] DumpData,
  output logic             DumpDone,
  output logic             Busy,
  output logic             BankRead,
  output logic [8:0]       BankAddr,
  output logic             BankListo,
  output logic             BankError,
  output logic [Width-1:0] BankDato,
  output logic [Width-1:0] BankEntrada,
  input  logic [Width-1:0] BankData
);

  rb_state_e  state, state_nxt;
  logic [8:0] rd_addr_q;
  logic [6:0] idx_q;
  logic       dump_active_q;
  logic       rd_go;
  logic       hs;
  logic       last;
  logic       clr_listo_rd;
  logic       clr_err_rd;

  // RdReq is still held during the RdValid cycle; don't re-launch on it.
  assign rd_go = RdReq & ~RdValid;
  assign hs    = (state == DUMP_WAIT) & DumpReady;
  assign last  = (idx_q == 7'(NumWords - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_go)          state_nxt = PROC_RD;
        else if (DumpStart) state_nxt = DUMP_RD;
      end
      PROC_RD:   state_nxt = dump_active_q ? DUMP_RD : IDLE;
      DUMP_RD:   state_nxt = DUMP_WAIT;
      DUMP_WAIT: begin
        if (hs) begin
          if (last)       state_nxt = DONE;
          else if (rd_go) state_nxt = PROC_RD;
          else            state_nxt = DUMP_RD;
        end
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BankRead  = 1'b0;
    BankAddr  = '0;
    DumpValid = 1'b0;
    DumpDone  = 1'b0;
    Busy      = (state != IDLE);
    case (state)
      PROC_RD: begin
        BankRead = 1'b1;
        BankAddr = rd_addr_q;
      end
      DUMP_RD: begin
        BankRead = 1'b1;
        BankAddr = word_addr(idx_q);
      end
      DUMP_WAIT: DumpValid = 1'b1;
      DONE:      DumpDone  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RdData        <= '0;
      RdValid       <= 1'b0;
      DumpAddr      <= '0;
      DumpData      <= '0;
      rd_addr_q     <= '0;
      idx_q         <= '0;
      dump_active_q <= 1'b0;
    end else begin
      RdValid <= (state == PROC_RD);
      if (state == PROC_RD) RdData <= BankData;
      if (state == DUMP_RD) begin
        DumpData <= BankData;
        DumpAddr <= word_addr(idx_q);
      end
      if (state != PROC_RD && state_nxt == PROC_RD) rd_addr_q <= RdAddr;
      if (state == IDLE && !rd_go && DumpStart) begin
        dump_active_q <= 1'b1;
        idx_q         <= '0;
      end
      if (hs && !last) idx_q <= idx_q + 7'd1;
      if (state == DONE) begin
        dump_active_q <= 1'b0;
        idx_q         <= '0;
      end
    end
  end

`ifdef NN_RB_CLEAR_ON_READ_EN
  assign clr_listo_rd = (state == PROC_RD) && (rd_addr_q == ADDR_LISTO);
  assign clr_err_rd   = (state == PROC_RD) && (rd_addr_q == ADDR_ERROR);
`else
  assign clr_listo_rd = 1'b0;
  assign clr_err_rd   = 1'b0;
`endif

  nn_rb_snapshot #(.Width(Width)) u_snapshot (
    .clk           (clk),
    .reset_n       (reset_n),
    .listo         (Listo),
    .error_in      (ErrorIn),
    .dato_in       (DatoIn),
    .entrada_in    (EntradaIn),
    .clear_flags   (ClearFlags),
    .clr_listo_rd  (clr_listo_rd),
    .clr_err_rd    (clr_err_rd),
    .dump_active   (dump_active_q),
    .apply_pending (state == DONE),
    .listo_flag    (BankListo),
    .err_flag      (BankError),
    .snap_dato     (BankDato),
    .snap_entrada  (BankEntrada)
  );

endmodule

// File: tb/tb_nn_readback_sequencer.sv
// Directed bench for nn_readback_sequencer with a behavioural register bank.
module tb_nn_readback_sequencer;

  localparam int W = 4;
`ifdef NN_RB_CLEAR_ON_READ_EN
  localparam int COR = 1;
`else
  localparam int COR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         Listo, ErrorIn, ClearFlags, RdReq, DumpStart, DumpReady;
  logic [W-1:0] DatoIn, EntradaIn, RdData, DumpData, BankDato, BankEntrada, BankData;
  logic [8:0]   RdAddr, DumpAddr, BankAddr;
  logic         RdValid, DumpValid, DumpDone, Busy, BankRead, BankListo, BankError;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_listo, exp_err, exp_dato, exp_ent;
  int n;

  always #5 clk = ~clk;

  nn_readback_sequencer #(.Width(W), .NumWords(35)) dut (
    .clk(clk), .reset_n(reset_n), .Listo(Listo), .ErrorIn(ErrorIn),
    .DatoIn(DatoIn), .EntradaIn(EntradaIn), .ClearFlags(ClearFlags),
    .RdReq(RdReq), .RdAddr(RdAddr), .RdData(RdData), .RdValid(RdValid),
    .DumpStart(DumpStart), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpDone(DumpDone), .Busy(Busy),
    .BankRead(BankRead), .BankAddr(BankAddr), .BankListo(BankListo),
    .BankError(BankError), .BankDato(BankDato), .BankEntrada(BankEntrada),
    .BankData(BankData)
  );

  // Register bank: four live registers, every other word reads addr[5:2].
  always_comb begin
    case (BankAddr)
      9'h000:  BankData = {3'b000, BankListo};
      9'h004:  BankData = BankDato;
      9'h008:  BankData = {3'b000, BankError};
      9'h060:  BankData = BankEntrada;
      default: BankData = BankAddr[5:2];
    endcase
  end

  always @(negedge clk) if (DumpDone === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    case (a)
      0:       return 32'(exp_listo);
      4:       return 32'(exp_dato);
      8:       return 32'(exp_err);
      96:      return 32'(exp_ent);
      default: return 32'((a >> 2) & 15);
    endcase
  endfunction

  task automatic do_read(input logic [8:0] a, input int exp, input string tag);
    RdReq = 1'b1;
    RdAddr = a;
    @(negedge clk); chk({tag, "_lat"}, 32'(RdValid), 32'd0);
    @(negedge clk); chk({tag, "_vld"}, 32'(RdValid), 32'd1);
    chk(tag, 32'(RdData), 32'(exp));
    RdReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_listo(input logic [W-1:0] d, input logic [W-1:0] e);
    Listo = 1'b1; DatoIn = d; EntradaIn = e;
    @(negedge clk);
    Listo = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (DumpValid !== 1'b1 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("dump_valid", 32'(DumpValid), 32'd1);
  endtask

  task automatic start_dump(input bit inj);
    DumpStart = 1'b1;
    @(negedge clk);
    DumpStart = 1'b0;
    if (inj) begin
      Listo = 1'b1; DatoIn = 4'hA; EntradaIn = 4'h9;
    end
    chk("dump_lat1", 32'(DumpValid), 32'd0);
    @(negedge clk);
    Listo = 1'b0;
    chk("dump_lat2", 32'(DumpValid), 32'd1);
  endtask

  task automatic dump_words(input int first, input int last);
    int w;
    for (int i = first; i <= last; i++) begin
      wait_valid(w);
      if (i > first) chk("dump_gap", 32'(w), 32'd1);
      chk("dump_addr", 32'(DumpAddr), 32'(i * 4));
      chk("dump_data", 32'(DumpData), exp_word(i * 4));
      @(negedge clk);
    end
  endtask

  task automatic finish_dump(input int exp_done);
    chk("done_pulse", 32'(DumpDone), 32'd1);
    @(negedge clk);
    chk("busy_after_dump", 32'(Busy), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; Listo = 0; ErrorIn = 0; ClearFlags = 0; RdReq = 0; DumpStart = 0;
    DumpReady = 1'b1; DatoIn = '0; EntradaIn = '0; RdAddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {Busy, RdValid, DumpValid, DumpDone, BankRead, BankListo, BankError},
        32'd0);
    chk("rst_data", {RdData, DumpData, BankDato, BankEntrada, DumpAddr, BankAddr}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Result capture and processor reads
    pulse_listo(4'h5, 4'h3);
    do_read(9'h000, 1, "rd_listo");
    do_read(9'h000, (COR != 0) ? 0 : 1, "rd_listo_again");
    do_read(9'h004, 5, "rd_dato");
    do_read(9'h060, 3, "rd_entrada");
    do_read(9'h014, 5, "rd_plain");

    // Set beats clear in the same cycle
    ErrorIn = 1'b1; ClearFlags = 1'b1;
    @(negedge clk);
    ErrorIn = 1'b0; ClearFlags = 1'b0;
    do_read(9'h008, 1, "rd_err_set_wins");
    ClearFlags = 1'b1;
    @(negedge clk);
    ClearFlags = 1'b0;
    do_read(9'h000, 0, "rd_listo_cleared");
    do_read(9'h008, 0, "rd_err_cleared");
    ErrorIn = 1'b1;
    @(negedge clk);
    ErrorIn = 1'b0;
    pulse_listo(4'h5, 4'h3);
    exp_listo = 1; exp_err = 1; exp_dato = 5; exp_ent = 3;

    // Full dump with consumer always ready
    start_dump(1'b0);
    dump_words(0, 34);
    finish_dump(1);

    // Stall at word 3 with a processor read queued behind it
    start_dump(1'b0);
    dump_words(0, 2);
    DumpReady = 1'b0;
    RdReq = 1'b1;
    RdAddr = 9'h060;
    wait_valid(n);
    for (int k = 0; k < 10; k++) begin
      chk("stall_hold", {DumpValid, RdValid, DumpAddr, DumpData},
          {1'b1, 1'b0, 9'h00C, 4'h3});
      @(negedge clk);
    end
    DumpReady = 1'b1;
    @(negedge clk);
    chk("stall_procrd", {Busy, DumpValid, RdValid}, 32'b100);
    @(negedge clk);
    chk("stall_rdvalid", 32'(RdValid), 32'd1);
    chk("stall_rddata", 32'(RdData), 32'd3);
    RdReq = 1'b0;
    dump_words(4, 34);
    finish_dump(2);

    // Result arriving mid-dump is deferred until the dump completes
    start_dump(1'b1);
    dump_words(0, 34);
    finish_dump(3);
    exp_dato = 10; exp_ent = 9;
    do_read(9'h004, 10, "rd_dato_pending");
    do_read(9'h060, 9, "rd_entrada_pending");

    // Asynchronous reset in the middle of a dump
    start_dump(1'b0);
    dump_words(0, 9);
    wait_valid(n);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outs", {Busy, RdValid, DumpValid, DumpDone, BankRead, BankListo, BankError},
        32'd0);
    chk("arst_data", {RdData, DumpData, BankDato, BankEntrada, DumpAddr, BankAddr}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt), 32'd3);
    chk("arst_idle", 32'(Busy), 32'd0);
    do_read(9'h004, 0, "rd_dato_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
